// File: rtl/calc_pkg.sv
// Shared types and default widths for the calculator command sequencer.
package calc_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_IMM_W  = 16;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_ADDI = 4'd8,
        OP_LI   = 4'd9,
        OP_MOV  = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;
endpackage

// File: rtl/calc_alu.sv
// Combinational ALU: result plus zero / signed-overflow / illegal-opcode flags.
module calc_alu
    import calc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMM_W  = DEF_IMM_W
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              ovf,
    output logic              err
);
    localparam int M = DATA_W - 1;

    logic [DATA_W-1:0] imm_sx;
    logic [4:0]        shamt;

    assign imm_sx = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign shamt  = b[4:0];

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        err    = 1'b0;
        case (op)
            OP_ADD: begin
                result = a + b;
                ovf    = (a[M] == b[M]) && (result[M] != a[M]);
            end
            OP_SUB: begin
                result = a - b;
                ovf    = (a[M] != b[M]) && (result[M] != a[M]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $signed(a) >>> shamt;
            OP_ADDI: begin
                result = a + imm_sx;
                ovf    = (a[M] == imm_sx[M]) && (result[M] != a[M]);
            end
            OP_LI:   result = imm_sx;
            OP_MOV:  result = a;
            default: err = 1'b1;
        endcase
        // an illegal opcode reports neither zero nor overflow
        zero = !err && (result == '0);
    end
endmodule

// File: rtl/calc_ctrl.sv
// Four-state command sequencer: latch command, read register file, execute, write back.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int IMM_W  = DEF_IMM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [IMM_W-1:0]  cmd_imm,
    output logic [ADDR_W-1:0] readReg1,
    output logic [ADDR_W-1:0] readReg2,
    input  logic [DATA_W-1:0] readData1,
    input  logic [DATA_W-1:0] readData2,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              write,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_ovf,
    output logic              res_err
);
    state_e state_q, state_d;

    logic [3:0]        op_q;
    logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
    logic [IMM_W-1:0]  imm_q;

    logic [DATA_W-1:0] res_q;
    logic              zero_q, ovf_q, err_q;

    logic [DATA_W-1:0] alu_res;
    logic              alu_zero, alu_ovf, alu_err;

    calc_alu #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_alu (
        .op     (op_q),
        .a      (readData1),
        .b      (readData2),
        .imm    (imm_q),
        .result (alu_res),
        .zero   (alu_zero),
        .ovf    (alu_ovf),
        .err    (alu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Outside READ the read ports park at rd+1/rd+2 so the register file
    // never sees a write address matching a read address.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        write     = 1'b0;
        readReg1  = rd_q + ADDR_W'(1);
        readReg2  = rd_q + ADDR_W'(2);
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = ST_READ;
            end
            ST_READ: begin
                readReg1 = rs1_q;
                readReg2 = rs2_q;
                state_d  = ST_EXEC;
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB: begin
                res_valid = 1'b1;
                write     = !err_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            imm_q <= '0;
        end else if (state_q == ST_IDLE && cmd_valid) begin
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            rs1_q <= cmd_rs1;
            rs2_q <= cmd_rs2;
            imm_q <= cmd_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            res_q  <= alu_res;
            zero_q <= alu_zero;
            ovf_q  <= alu_ovf;
            err_q  <= alu_err;
        end
    end

    assign writeReg  = rd_q;
    assign writeData = res_q;
    assign res_data  = res_q;
    assign res_zero  = zero_q;
    assign res_ovf   = ovf_q;
    assign res_err   = err_q;
endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl with a behavioural 32x32 register file model.
module tb_calc_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic [15:0] cmd_imm;
    logic [4:0]  readReg1, readReg2, writeReg;
    logic [31:0] readData1, readData2, writeData, res_data;
    logic        write, res_valid, res_zero, res_ovf, res_err;

    logic [31:0] mem [32];
    logic        pl_en;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int wr_base;

    always #5 clk = ~clk;

    calc_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .cmd_imm   (cmd_imm),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .readData1 (readData1),
        .readData2 (readData2),
        .writeReg  (writeReg),
        .writeData (writeData),
        .write     (write),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_ovf   (res_ovf),
        .res_err   (res_err)
    );

    // Register file: registered reads; a write colliding with a read address is dropped.
    always @(posedge clk) begin
        readData1 <= mem[readReg1];
        readData2 <= mem[readReg2];
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (write && writeReg != readReg1 && writeReg != readReg2)
            mem[writeReg] <= writeData;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && write) begin
            wr_cnt++;
            check("park1", 32'(readReg1 != writeReg), 32'd1);
            check("park2", 32'(readReg2 != writeReg), 32'd1);
        end
    end

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of cycle 4.
    task automatic run_cmd(input string nm, input logic [3:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [15:0] imm,
                           input logic exp_wr, input logic [31:0] exp_data,
                           input logic exp_zero, input logic exp_ovf, input logic exp_err);
        check({nm, ".ready0"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_op = 4'hF; cmd_rd = 5'h1F; cmd_rs1 = 5'h1F; cmd_rs2 = 5'h1F; cmd_imm = 16'hDEAD;
        @(negedge clk);
        check({nm, ".rdaddr1"}, 32'(readReg1), 32'(rs1));
        check({nm, ".rdaddr2"}, 32'(readReg2), 32'(rs2));
        check({nm, ".ready_rd"}, 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check({nm, ".wr_exec"}, 32'(write), 32'd0);
        check({nm, ".vld_exec"}, 32'(res_valid), 32'd0);
        @(negedge clk);
        check({nm, ".write"}, 32'(write), 32'(exp_wr));
        check({nm, ".res_valid"}, 32'(res_valid), 32'd1);
        check({nm, ".data"}, res_data, exp_data);
        check({nm, ".zero"}, 32'(res_zero), 32'(exp_zero));
        check({nm, ".ovf"}, 32'(res_ovf), 32'(exp_ovf));
        check({nm, ".err"}, 32'(res_err), 32'(exp_err));
        if (exp_wr) begin
            check({nm, ".wreg"}, 32'(writeReg), 32'(rd));
            check({nm, ".wdata"}, writeData, exp_data);
        end
        @(negedge clk);
        check({nm, ".ready4"}, 32'(cmd_ready), 32'd1);
        check({nm, ".vld4"}, 32'(res_valid), 32'd0);
        check({nm, ".wr4"}, 32'(write), 32'd0);
        check({nm, ".hold"}, res_data, exp_data);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        cmd_imm = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        #1;
        check("rst.ready", 32'(cmd_ready), 32'd1);
        check("rst.write", 32'(write), 32'd0);
        check("rst.valid", 32'(res_valid), 32'd0);
        check("rst.data", res_data, 32'd0);
        check("rst.flags", {29'd0, res_zero, res_ovf, res_err}, 32'd0);
        check("rst.rr1", 32'(readReg1), 32'd1);
        check("rst.rr2", 32'(readReg2), 32'd2);
        check("rst.wreg", 32'(writeReg), 32'd0);
        check("rst.wdata", writeData, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd("li3", 4'd9, 5'd3, 5'd0, 5'd0, 16'h7FFF, 1'b1, 32'h0000_7FFF, 1'b0, 1'b0, 1'b0);
        run_cmd("li4", 4'd9, 5'd4, 5'd0, 5'd0, 16'hFFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        check("mem3", mem[3], 32'h0000_7FFF);
        check("mem4", mem[4], 32'hFFFF_FFFF);
        run_cmd("xor", 4'd4, 5'd15, 5'd3, 5'd4, 16'h0, 1'b1, 32'hFFFF_8000, 1'b0, 1'b0, 1'b0);

        preload(5'd1, 32'h7FFF_FFFF);
        preload(5'd2, 32'd1);
        run_cmd("add_ovf", 4'd0, 5'd5, 5'd1, 5'd2, 16'h0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_cmd("sub_zero", 4'd1, 5'd6, 5'd2, 5'd2, 16'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        check("mem5", mem[5], 32'h8000_0000);

        preload(5'd7, 32'h8000_0000);
        preload(5'd8, 32'd4);
        run_cmd("sra", 4'd7, 5'd10, 5'd7, 5'd8, 16'h0, 1'b1, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
        run_cmd("srl", 4'd6, 5'd11, 5'd7, 5'd8, 16'h0, 1'b1, 32'h0800_0000, 1'b0, 1'b0, 1'b0);
        preload(5'd8, 32'd33);
        run_cmd("sll", 4'd5, 5'd12, 5'd7, 5'd8, 16'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);

        preload(5'd1, 32'd5);
        run_cmd("add_self", 4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 1'b1, 32'd10, 1'b0, 1'b0, 1'b0);
        run_cmd("mov", 4'd10, 5'd9, 5'd1, 5'd0, 16'h0, 1'b1, 32'd10, 1'b0, 1'b0, 1'b0);
        check("mem9", mem[9], 32'd10);
        run_cmd("addi", 4'd8, 5'd14, 5'd1, 5'd0, 16'hFFFE, 1'b1, 32'd8, 1'b0, 1'b0, 1'b0);

        wr_base = wr_cnt;
        run_cmd("illegal", 4'd12, 5'd13, 5'd1, 5'd1, 16'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("illegal.nowr", 32'(wr_cnt - wr_base), 32'd0);

        // Reset mid-command: ADD r2,r1,r1 is killed during EXEC.
        wr_base = wr_cnt;
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_rd = 5'd2; cmd_rs1 = 5'd1; cmd_rs2 = 5'd1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst.write", 32'(write), 32'd0);
        check("arst.valid", 32'(res_valid), 32'd0);
        check("arst.ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("arst.nowr", 32'(wr_cnt - wr_base), 32'd0);
        check("arst.r2", mem[2], 32'd1);
        check("arst.ready2", 32'(cmd_ready), 32'd1);
        run_cmd("post_rst", 4'd9, 5'd13, 5'd0, 5'd0, 16'h1234, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
        check("mem13", mem[13], 32'h0000_1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
